// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC stage: branch codes (common with the branch
// checker and decoder) and the sequencer state encoding.
package pc_sequencer_pkg;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_REG  = 3'b001;
  localparam logic [2:0] BR_LINK = 3'b010;
  localparam logic [2:0] BR_LTZ  = 3'b011;
  localparam logic [2:0] BR_Z    = 3'b100;
  localparam logic [2:0] BR_NZ   = 3'b101;
  localparam logic [2:0] BR_CY   = 3'b110;
  localparam logic [2:0] BR_NCY  = 3'b111;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    BUBBLE = 2'b10,
    HALT   = 2'b11
  } state_e;

  // A jump decision without a branch code is not a redirect.
  function automatic logic is_taken(input logic [2:0] branch, input logic jump);
    return jump && (branch != BR_NONE);
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/address bundle between the pipeline front end and the PC sequencer.
interface pc_sequencer_if #(parameter int AW = 32);

  logic          start;
  logic          stall;
  logic          halt_req;
  logic [2:0]    branch;
  logic          jump;
  logic [AW-1:0] imm_target;
  logic [AW-1:0] reg_target;
  logic [AW-1:0] pc;
  logic          instr_valid;
  logic          flush;
  logic          link_we;
  logic [AW-1:0] link_addr;
  logic          halted;

  modport master (
    output start, stall, halt_req, branch, jump, imm_target, reg_target,
    input  pc, instr_valid, flush, link_we, link_addr, halted
  );

  modport slave (
    input  start, stall, halt_req, branch, jump, imm_target, reg_target,
    output pc, instr_valid, flush, link_we, link_addr, halted
  );

endinterface

// File: rtl/pc_sequencer_pc_next_mux.sv
// Combinational next-PC select: redirect target when taken, else pc+1 (wrapping).
module pc_next_mux
  import pc_sequencer_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic [AW-1:0] i_pc,
  input  logic [2:0]    i_branch,
  input  logic          i_jump,
  input  logic [AW-1:0] i_imm_target,
  input  logic [AW-1:0] i_reg_target,
  output logic [AW-1:0] o_next_pc,
  output logic          o_taken
);

  logic [AW-1:0] w_target;

  // Register branches use the register operand; all other codes are absolute.
  always_comb begin
    w_target  = i_imm_target;
    o_taken   = is_taken(i_branch, i_jump);
    o_next_pc = i_pc + {{(AW-1){1'b0}}, 1'b1};
    if (i_branch == BR_REG) begin
      w_target = i_reg_target;
    end else begin
      w_target = i_imm_target;
    end
    if (o_taken) begin
      o_next_pc = w_target;
    end else begin
      o_next_pc = i_pc + {{(AW-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: start-up, stall, post-redirect bubble, link write
// and terminal halt. All outputs come straight from registers.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int            AW       = 32,
  parameter logic [AW-1:0] RESET_PC = {AW{1'b0}}
) (
  input  logic           clk,
  input  logic           rst_n,
  pc_sequencer_if.slave  bus
);

  state_e        r_state;
  logic [AW-1:0] r_pc;
  logic          r_instr_valid;
  logic          r_flush;
  logic          r_link_we;
  logic [AW-1:0] r_link_addr;
  logic          r_halted;
  logic [AW-1:0] w_next_pc;
  logic          w_taken;

  pc_next_mux #(.AW(AW)) u_next_mux (
    .i_pc         (r_pc),
    .i_branch     (bus.branch),
    .i_jump       (bus.jump),
    .i_imm_target (bus.imm_target),
    .i_reg_target (bus.reg_target),
    .o_next_pc    (w_next_pc),
    .o_taken      (w_taken)
  );

  // State machine and registered outputs; flush/link_we default low so they pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_pc          <= RESET_PC;
      r_instr_valid <= 1'b0;
      r_flush       <= 1'b0;
      r_link_we     <= 1'b0;
      r_link_addr   <= {AW{1'b0}};
      r_halted      <= 1'b0;
    end else begin
      r_flush   <= 1'b0;
      r_link_we <= 1'b0;
      case (r_state)
        IDLE: begin
          r_pc <= RESET_PC;
          if (bus.start) begin
            r_state       <= RUN;
            r_instr_valid <= 1'b1;
          end else begin
            r_instr_valid <= 1'b0;
          end
        end
        RUN: begin
          if (bus.stall) begin
            r_state <= RUN;
          end else if (bus.halt_req) begin
            r_state       <= HALT;
            r_instr_valid <= 1'b0;
            r_halted      <= 1'b1;
          end else if (w_taken) begin
            r_state       <= BUBBLE;
            r_pc          <= w_next_pc;
            r_flush       <= 1'b1;
            r_instr_valid <= 1'b0;
            if (bus.branch == BR_LINK) begin
              r_link_we   <= 1'b1;
              r_link_addr <= r_pc + {{(AW-1){1'b0}}, 1'b1};
            end else begin
              r_link_we   <= 1'b0;
            end
          end else begin
            r_pc <= w_next_pc;
          end
        end
        BUBBLE: begin
          if (bus.stall) begin
            r_state <= BUBBLE;
          end else if (bus.halt_req) begin
            r_state  <= HALT;
            r_halted <= 1'b1;
          end else begin
            r_state       <= RUN;
            r_instr_valid <= 1'b1;
          end
        end
        HALT: begin
          r_instr_valid <= 1'b0;
          r_halted      <= 1'b1;
        end
        default: begin
          r_state       <= IDLE;
          r_pc          <= RESET_PC;
          r_instr_valid <= 1'b0;
          r_halted      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc          = r_pc;
  assign bus.instr_valid = r_instr_valid;
  assign bus.flush       = r_flush;
  assign bus.link_we     = r_link_we;
  assign bus.link_addr   = r_link_addr;
  assign bus.halted      = r_halted;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: start-up, branches, link, stall priority,
// halt, PC wrap (second instance) and asynchronous reset during a bubble.
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  pc_sequencer_if #(.AW(32)) ifa ();
  pc_sequencer_if #(.AW(32)) ifb ();

  pc_sequencer #(.AW(32), .RESET_PC(32'h0000_0000)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa.slave)
  );

  pc_sequencer #(.AW(32), .RESET_PC(32'hFFFF_FFFE)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_a();
    ifa.stall      = 1'b0;
    ifa.halt_req   = 1'b0;
    ifa.branch     = BR_NONE;
    ifa.jump       = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    ifa.start = 1'b0; ifa.imm_target = 32'h0; ifa.reg_target = 32'h0;
    clear_a();
    ifb.start = 1'b0; ifb.stall = 1'b0; ifb.halt_req = 1'b0;
    ifb.branch = BR_NONE; ifb.jump = 1'b0;
    ifb.imm_target = 32'h0; ifb.reg_target = 32'h0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_pc",        ifa.pc,          32'h0);
    check("rst_valid",     ifa.instr_valid, 32'h0);
    check("rst_flush",     ifa.flush,       32'h0);
    check("rst_link_we",   ifa.link_we,     32'h0);
    check("rst_link_addr", ifa.link_addr,   32'h0);
    check("rst_halted",    ifa.halted,      32'h0);
    check("rst_pc_b",      ifb.pc,          32'hFFFF_FFFE);

    rst_n = 1'b1;
    step();
    check("idle_valid", ifa.instr_valid, 32'h0);

    ifa.start = 1'b1; ifb.start = 1'b1;
    step();
    ifa.start = 1'b0; ifb.start = 1'b0;
    check("start_pc",    ifa.pc,          32'h0);
    check("start_valid", ifa.instr_valid, 32'h1);
    check("wrap_pc0",    ifb.pc,          32'hFFFF_FFFE);
    step();
    check("run_pc1",  ifa.pc, 32'h1);
    check("wrap_pc1", ifb.pc, 32'hFFFF_FFFF);
    step();
    check("run_pc2",  ifa.pc, 32'h2);
    check("wrap_pc2", ifb.pc, 32'h0);
    step();
    check("run_pc3", ifa.pc, 32'h3);
    step();
    step();
    check("run_pc5", ifa.pc, 32'h5);

    // absolute conditional branch at pc=5
    ifa.branch = BR_Z; ifa.jump = 1'b1; ifa.imm_target = 32'h40;
    step();
    clear_a();
    check("br_pc",    ifa.pc,          32'h40);
    check("br_flush", ifa.flush,       32'h1);
    check("br_valid", ifa.instr_valid, 32'h0);
    step();
    check("bub_pc",    ifa.pc,          32'h40);
    check("bub_valid", ifa.instr_valid, 32'h1);
    check("bub_flush", ifa.flush,       32'h0);
    step();
    check("after_br_pc", ifa.pc, 32'h41);

    ifa.branch = BR_NONE; ifa.jump = 1'b1;
    step();
    clear_a();
    check("nobr_pc",    ifa.pc,    32'h42);
    check("nobr_flush", ifa.flush, 32'h0);

    // register branch to 9, then branch-and-link at pc=9
    ifa.branch = BR_REG; ifa.jump = 1'b1; ifa.reg_target = 32'h9; ifa.imm_target = 32'h200;
    step();
    clear_a();
    check("rbr_pc",      ifa.pc,      32'h9);
    check("rbr_flush",   ifa.flush,   32'h1);
    check("rbr_link_we", ifa.link_we, 32'h0);
    step();
    check("rbr_valid", ifa.instr_valid, 32'h1);

    ifa.branch = BR_LINK; ifa.jump = 1'b1; ifa.imm_target = 32'h100;
    step();
    clear_a();
    check("lnk_we",    ifa.link_we,   32'h1);
    check("lnk_addr",  ifa.link_addr, 32'hA);
    check("lnk_pc",    ifa.pc,        32'h100);
    check("lnk_flush", ifa.flush,     32'h1);
    step();
    check("lnk_we_off",  ifa.link_we,     32'h0);
    check("lnk_addr_hd", ifa.link_addr,   32'hA);
    check("lnk_valid",   ifa.instr_valid, 32'h1);

    // return via register, stalling once in the bubble
    ifa.branch = BR_REG; ifa.jump = 1'b1; ifa.reg_target = 32'hA;
    step();
    clear_a();
    check("ret_pc", ifa.pc, 32'hA);
    ifa.stall = 1'b1;
    step();
    check("bstall_valid", ifa.instr_valid, 32'h0);
    check("bstall_pc",    ifa.pc,          32'hA);
    ifa.stall = 1'b0;
    step();
    check("ret_valid", ifa.instr_valid, 32'h1);
    step();
    check("ret_pc_inc", ifa.pc, 32'hB);

    // stall outranks halt and taken branch
    ifa.stall = 1'b1; ifa.jump = 1'b1; ifa.branch = BR_NZ; ifa.imm_target = 32'h80;
    ifa.halt_req = 1'b1;
    step();
    step();
    check("stl_pc",     ifa.pc,          32'hB);
    check("stl_flush",  ifa.flush,       32'h0);
    check("stl_halted", ifa.halted,      32'h0);
    check("stl_link",   ifa.link_we,     32'h0);
    check("stl_valid",  ifa.instr_valid, 32'h1);
    ifa.stall = 1'b0;
    step();
    check("hlt_halted", ifa.halted,      32'h1);
    check("hlt_valid",  ifa.instr_valid, 32'h0);
    check("hlt_pc",     ifa.pc,          32'hB);
    check("hlt_flush",  ifa.flush,       32'h0);
    clear_a();
    ifa.start = 1'b1; ifa.jump = 1'b1; ifa.branch = BR_Z;
    step();
    step();
    ifa.start = 1'b0;
    clear_a();
    check("hlt_hold_pc",  ifa.pc,          32'hB);
    check("hlt_hold_h",   ifa.halted,      32'h1);
    check("hlt_hold_val", ifa.instr_valid, 32'h0);

    // asynchronous reset while flush/link_we pulse in the bubble
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("rst2_halted", ifa.halted, 32'h0);
    ifa.start = 1'b1;
    step();
    ifa.start = 1'b0;
    check("rst2_pc", ifa.pc, 32'h0);
    ifa.branch = BR_LINK; ifa.jump = 1'b1; ifa.imm_target = 32'h30;
    step();
    clear_a();
    check("pre_flush",   ifa.flush,   32'h1);
    check("pre_link_we", ifa.link_we, 32'h1);
    check("pre_pc",      ifa.pc,      32'h30);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_pc",        ifa.pc,          32'h0);
    check("arst_valid",     ifa.instr_valid, 32'h0);
    check("arst_flush",     ifa.flush,       32'h0);
    check("arst_link_we",   ifa.link_we,     32'h0);
    check("arst_link_addr", ifa.link_addr,   32'h0);
    check("arst_halted",    ifa.halted,      32'h0);
    step();
    check("arst_idle_valid", ifa.instr_valid, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
